// File: rtl/timer_intrp_ctl.sv
// rtl/timer_intrp_ctl.sv - timer event status/control registers with interrupt and watchdog escalation
//
// Purpose: latches per-channel timer events into a sticky status register (TSR),
//          masks them with a control register (TCR) into registered interrupt
//          requests, and serves SPR reads/writes of TSR, TCR and PEND (TSR & TCR).
//          Optional watchdog escalation on channel 0 is compiled in with the
//          macro TIMER_INTRP_CTL_WDOG_ESC_EN.
//
// Ports:
//   CB          clock, all state updates on its rising edge
//   resetCore   synchronous active-high reset
//   timerEvent  per-channel single-cycle event pulses
//   sprWrEn     SPR write strobe
//   sprRdEn     SPR read strobe
//   sprSel      register select: 0=TSR (W1C), 1=TCR, 2=PEND (read only), 3=reserved
//   sprWrData   SPR write data, bits [NCH-1:0] significant
//   sprRdData   registered read data, held between reads
//   sprRdVal    one-cycle read-valid per read strobe
//   TIM_intrp   registered per-channel interrupt requests
//   TIM_rstReq  watchdog reset request (0 when escalation is compiled out)
module timer_intrp_ctl #(
   parameter int NCH = 3,
   parameter int DW  = 32
) (
   input  logic           CB,
   input  logic           resetCore,
   input  logic [NCH-1:0] timerEvent,
   input  logic           sprWrEn,
   input  logic           sprRdEn,
   input  logic [1:0]     sprSel,
   input  logic [DW-1:0]  sprWrData,
   output logic [DW-1:0]  sprRdData,
   output logic           sprRdVal,
   output logic [NCH-1:0] TIM_intrp,
   output logic           TIM_rstReq
);

   logic [NCH-1:0] tsr_q, tsr_d;
   logic [NCH-1:0] tcr_q, tcr_d;
   logic [NCH-1:0] intrp_q, intrp_d;
   logic [DW-1:0]  rd_data_q, rd_data_d;
   logic           rd_val_q, rd_val_d;
   logic [NCH-1:0] w1c;
   logic [NCH-1:0] rd_sel;

   // Write data above NCH carries no register bits.
   logic unused_wr_hi;
   assign unused_wr_hi = ^sprWrData[DW-1:NCH];

   always_comb begin
      w1c       = '0;
      rd_sel    = '0;
      tcr_d     = tcr_q;
      rd_data_d = rd_data_q;

      if (sprWrEn && (sprSel == 2'd0)) begin
         w1c = sprWrData[NCH-1:0];
      end
      // OR-ing the event after the clear makes a same-cycle set win.
      tsr_d = (tsr_q & ~w1c) | timerEvent;

      if (sprWrEn && (sprSel == 2'd1)) begin
         tcr_d = sprWrData[NCH-1:0];
      end

      intrp_d = tsr_q & tcr_q;

      // Read mux uses the current register values, so a same-cycle write is not visible.
      case (sprSel)
         2'd0:    rd_sel = tsr_q;
         2'd1:    rd_sel = tcr_q;
         2'd2:    rd_sel = tsr_q & tcr_q;
         default: rd_sel = '0;
      endcase
      if (sprRdEn) begin
         rd_data_d = {{(DW-NCH){1'b0}}, rd_sel};
      end
      rd_val_d = sprRdEn;
   end

   always_ff @(posedge CB) begin
      if (resetCore) begin
         tsr_q     <= '0;
         tcr_q     <= '0;
         intrp_q   <= '0;
         rd_data_q <= '0;
         rd_val_q  <= 1'b0;
      end else begin
         tsr_q     <= tsr_d;
         tcr_q     <= tcr_d;
         intrp_q   <= intrp_d;
         rd_data_q <= rd_data_d;
         rd_val_q  <= rd_val_d;
      end
   end

   assign TIM_intrp = intrp_q;
   assign sprRdData = rd_data_q;
   assign sprRdVal  = rd_val_q;

`ifdef TIMER_INTRP_CTL_WDOG_ESC_EN
   logic [1:0] stage_q, stage_d;
   logic       rst_req_q, rst_req_d;

   // Stage counts watchdog events that arrive while the previous one is still
   // unacknowledged; acknowledging channel 0 restarts the count.
   always_comb begin
      stage_d = stage_q;
      if (w1c[0]) begin
         stage_d = 2'd0;
      end else if (timerEvent[0] && tsr_q[0] && (stage_q != 2'd2)) begin
         stage_d = stage_q + 2'd1;
      end
      // Sticky until resetCore.
      rst_req_d = rst_req_q | (stage_q == 2'd2);
   end

   always_ff @(posedge CB) begin
      if (resetCore) begin
         stage_q   <= 2'd0;
         rst_req_q <= 1'b0;
      end else begin
         stage_q   <= stage_d;
         rst_req_q <= rst_req_d;
      end
   end

   assign TIM_rstReq = rst_req_q;
`else
   assign TIM_rstReq = 1'b0;
`endif

endmodule

// File: tb/tb_timer_intrp_ctl.sv
// tb/tb_timer_intrp_ctl.sv - scoreboard bench for timer_intrp_ctl
module tb_timer_intrp_ctl;

   localparam int NCH = 3;
   localparam int DW  = 32;

   logic           CB;
   logic           resetCore;
   logic [NCH-1:0] timerEvent;
   logic           sprWrEn;
   logic           sprRdEn;
   logic [1:0]     sprSel;
   logic [DW-1:0]  sprWrData;
   logic [DW-1:0]  sprRdData;
   logic           sprRdVal;
   logic [NCH-1:0] TIM_intrp;
   logic           TIM_rstReq;

   timer_intrp_ctl #(.NCH(NCH), .DW(DW)) dut (
      .CB         (CB),
      .resetCore  (resetCore),
      .timerEvent (timerEvent),
      .sprWrEn    (sprWrEn),
      .sprRdEn    (sprRdEn),
      .sprSel     (sprSel),
      .sprWrData  (sprWrData),
      .sprRdData  (sprRdData),
      .sprRdVal   (sprRdVal),
      .TIM_intrp  (TIM_intrp),
      .TIM_rstReq (TIM_rstReq)
   );

   initial CB = 1'b0;
   always #5 CB = ~CB;

   typedef struct {
      logic [NCH-1:0] intrp;
      logic           rst;
      logic           val;
      logic [DW-1:0]  data;
   } exp_t;

   exp_t          cyc_q[$];
   logic [DW-1:0] rd_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: one flag per channel plus a count of unacknowledged repeats.
   bit            m_tsr [NCH];
   bit            m_tcr [NCH];
   bit [DW-1:0]   m_data;
   int            m_repeats;
   bit            m_rst;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit [DW-1:0] model_read(input bit [1:0] sel);
      bit [DW-1:0] v = '0;
      for (int i = 0; i < NCH; i++) begin
         case (sel)
            2'd0:    v[i] = m_tsr[i];
            2'd1:    v[i] = m_tcr[i];
            2'd2:    v[i] = m_tsr[i] && m_tcr[i];
            default: v[i] = 1'b0;
         endcase
      end
      return v;
   endfunction

   // Applies one cycle of inputs and records what the DUT must show after the next edge.
   task automatic step(input bit rst, input bit [NCH-1:0] ev, input bit we, input bit re,
                       input bit [1:0] sel, input bit [DW-1:0] wd);
      exp_t e;
      bit   clr0;
      @(negedge CB);
      resetCore  = rst;
      timerEvent = ev;
      sprWrEn    = we;
      sprRdEn    = re;
      sprSel     = sel;
      sprWrData  = wd;
      if (rst) begin
         e.intrp = '0; e.rst = 1'b0; e.val = 1'b0; e.data = '0;
         for (int i = 0; i < NCH; i++) begin
            m_tsr[i] = 1'b0;
            m_tcr[i] = 1'b0;
         end
         m_data = '0; m_repeats = 0; m_rst = 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) e.intrp[i] = m_tsr[i] && m_tcr[i];
`ifdef TIMER_INTRP_CTL_WDOG_ESC_EN
         e.rst = m_rst || (m_repeats >= 2);
`else
         e.rst = 1'b0;
`endif
         e.val = re;
         if (re) begin
            m_data = model_read(sel);
            rd_q.push_back(m_data);
         end
         e.data = m_data;
         m_rst  = e.rst;
         clr0 = we && (sel == 2'd0) && wd[0];
         if (clr0) m_repeats = 0;
         else if (ev[0] && m_tsr[0] && m_repeats < 2) m_repeats = m_repeats + 1;
         for (int i = 0; i < NCH; i++) begin
            if (ev[i]) m_tsr[i] = 1'b1;
            else if (we && (sel == 2'd0) && wd[i]) m_tsr[i] = 1'b0;
            if (we && (sel == 2'd1)) m_tcr[i] = wd[i];
         end
      end
      cyc_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, '0, 0, 0, 2'd0, '0);
   endtask

   // Monitor: compares one expected cycle after every edge, and pops a read on valid.
   initial begin
      exp_t e;
      logic [DW-1:0] r;
      forever begin
         @(posedge CB);
         #1;
         if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("intrp",  {{(DW-NCH){1'b0}}, TIM_intrp}, {{(DW-NCH){1'b0}}, e.intrp});
            chk("rstReq", {{(DW-1){1'b0}}, TIM_rstReq},   {{(DW-1){1'b0}}, e.rst});
            chk("rdVal",  {{(DW-1){1'b0}}, sprRdVal},     {{(DW-1){1'b0}}, e.val});
            chk("rdData", sprRdData, e.data);
            if (sprRdVal === 1'b1) begin
               if (rd_q.size() == 0) begin
                  chk("rdUnexpected", {{(DW-1){1'b0}}, sprRdVal}, '0);
               end else begin
                  r = rd_q.pop_front();
                  chk("rdScore", sprRdData, r);
               end
            end
         end
      end
   end

   initial begin
      bit [NCH-1:0] ev;
      resetCore  = 1'b1;
      timerEvent = '0;
      sprWrEn    = 1'b0;
      sprRdEn    = 1'b0;
      sprSel     = 2'd0;
      sprWrData  = '0;

      step(1, '0, 0, 0, 2'd0, '0);
      step(1, '0, 0, 0, 2'd0, '0);

      // TCR=101, event on channel 0: status next cycle, interrupt the one after.
      step(0, '0, 1, 0, 2'd1, 32'h5);
      step(0, 3'b001, 0, 0, 2'd0, '0);
      idle(2);

      // Set wins over same-cycle W1C.
      step(0, 3'b111, 0, 0, 2'd0, '0);
      step(0, 3'b010, 1, 0, 2'd0, 32'h2);
      step(0, '0, 0, 1, 2'd0, '0);
      idle(1);

      // PEND read, reserved read, then a read colliding with a write.
      step(1, '0, 0, 0, 2'd0, '0);
      step(0, 3'b011, 1, 0, 2'd1, 32'h6);
      step(0, '0, 0, 1, 2'd2, '0);
      step(0, '0, 0, 1, 2'd3, '0);
      step(0, '0, 1, 1, 2'd1, 32'hFFFF_FFF9);
      step(0, '0, 1, 0, 2'd2, 32'h7);
      step(0, '0, 1, 1, 2'd3, 32'h7);
      step(0, '0, 0, 1, 2'd1, '0);
      idle(2);

      // Three unacknowledged watchdog events, then reset.
      step(1, '0, 0, 0, 2'd0, '0);
      for (int k = 0; k < 3; k++) begin
         step(0, 3'b001, 0, 0, 2'd0, '0);
         idle(1);
      end
      idle(4);
      step(1, '0, 0, 0, 2'd0, '0);
      idle(1);

      // Reset with a concurrent read and TCR write.
      step(0, '0, 1, 0, 2'd1, 32'h7);
      step(1, '0, 1, 1, 2'd1, 32'h7);
      step(0, '0, 0, 1, 2'd1, '0);
      idle(1);

      // Randomized traffic.
      for (int k = 0; k < 600; k++) begin
         ev = '0;
         for (int i = 0; i < NCH; i++) ev[i] = ($urandom_range(0, 5) == 0);
         step(($urandom_range(0, 79) == 0), ev, ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), $urandom);
      end
      idle(3);

      @(negedge CB);
      @(negedge CB);
      chk("drainCycles", cyc_q.size(), 0);
      chk("drainReads",  rd_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/timer_intrp_ctl.md
TIMER_INTRP_CTL -- requirements
Module: timer_intrp_ctl

Interface
REQ-001 SHALL have parameter NCH, default 3, meaning number of timer event channels (1..16); channel 0 is the watchdog channel.
REQ-002 SHALL have parameter DW, default 32, meaning SPR data bus width (DW >= 2*NCH).
REQ-003 SHALL have port CB, input, 1, meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port resetCore, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port timerEvent, input, NCH, meaning per-channel single-cycle event pulses.
REQ-006 SHALL have port sprWrEn, input, 1, meaning SPR write strobe.
REQ-007 SHALL have port sprRdEn, input, 1, meaning SPR read strobe.
REQ-008 SHALL have port sprSel, input, 2, meaning register select: 0=TSR (status), 1=TCR (control), 2=PEND (status AND control), 3=reserved.
REQ-009 SHALL have port sprWrData, input, DW, meaning SPR write data; bits [NCH-1:0] are significant.
REQ-010 SHALL have port sprRdData, output, DW, meaning registered read data.
REQ-011 SHALL have port sprRdVal, output, 1, meaning sprRdData is valid.
REQ-012 SHALL have port TIM_intrp, output, NCH, meaning registered per-channel interrupt requests.
REQ-013 SHALL have port TIM_rstReq, output, 1, meaning watchdog reset request; constant 0 when the escalation feature is compiled out.

Function
REQ-014 SHALL set TSR[i] in the cycle after timerEvent[i]=1; TSR bits are sticky.
REQ-015 SHALL clear TSR[i] when sprWrEn=1, sprSel=0 and sprWrData[i]=1 (write-1-to-clear); a 0 data bit leaves TSR[i] unchanged.
REQ-016 SHALL let a set win over a clear when timerEvent[i] and the W1C for bit i occur in the same cycle.
REQ-017 SHALL load TCR[NCH-1:0] from sprWrData when sprWrEn=1 and sprSel=1.
REQ-018 SHALL ignore writes with sprSel=2 or 3, and SHALL also ignore all writes to TSR/TCR bits at index NCH or above.
REQ-019 SHALL drive TIM_intrp[i] = TSR[i] & TCR[i] as registered from the current register values, so an interrupt appears 2 cycles after its event pulse.
REQ-020 SHALL capture sprRdData one cycle after sprRdEn, zero-extended from NCH bits; sprSel=3 SHALL return all zeros.
REQ-021 SHALL assert sprRdVal for exactly one cycle per read strobe; back-to-back strobes SHALL give back-to-back valid cycles.
REQ-022 SHALL return pre-write register contents when a read and a write to the same register occur in the same cycle.
REQ-023 SHALL hold sprRdData between reads.

Reset
REQ-024 SHALL clear TSR, TCR, TIM_intrp, sprRdData, sprRdVal, TIM_rstReq and the escalation stage to 0 when resetCore=1 at a clock edge.
REQ-025 SHALL let reset take priority over event, write and read inputs in the same cycle; a read pending when reset occurs SHALL be dropped (no sprRdVal).

Configuration
REQ-026 SHALL implement watchdog escalation only when the macro TIMER_INTRP_CTL_WDOG_ESC_EN is defined.
REQ-027 With TIMER_INTRP_CTL_WDOG_ESC_EN defined, the 2-bit stage SHALL act as follows:
- stage increments (saturating at 2) when timerEvent[0]=1 while TSR[0] is already 1;
- stage clears when TSR[0] is cleared by a W1C;
- the W1C clear has priority over the increment in the same cycle.
REQ-028 With TIMER_INTRP_CTL_WDOG_ESC_EN defined, TIM_rstReq SHALL assert in the cycle after stage reaches 2, and SHALL stay high until resetCore.
REQ-029 Without TIMER_INTRP_CTL_WDOG_ESC_EN, the block SHALL contain no stage logic and SHALL tie TIM_rstReq to 0.

Verification
REQ-030 SHALL cover: NCH=3, TCR=3'b101, timerEvent=3'b001 at cycle 0 -> TSR=001 at cycle 1, TIM_intrp=001 at cycle 2.
REQ-031 SHALL cover: TSR=111, then W1C 3'b010 in the same cycle as timerEvent=3'b010 -> TSR stays 111.
REQ-032 SHALL cover: TSR=011, TCR=110, read with sprSel=2 -> sprRdVal=1 one cycle later with sprRdData=32'h2; then read with sprSel=3 -> 0.
REQ-033 SHALL cover (macro defined): three timerEvent[0] pulses with no clear -> TIM_rstReq=1 after the third pulse and held; then resetCore -> all outputs 0.
REQ-034 SHALL cover (macro undefined): the same stimulus as REQ-033 -> TIM_rstReq stays 0 throughout.
REQ-035 SHALL cover: resetCore asserted in the same cycle as sprRdEn and a TCR write -> next cycle TCR=0 and sprRdVal=0.
